csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_access_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// CSR access sequencer: read-modify-write of one CSR per request over IDLE/READ/WRITE/RESP.
// Optional macro CSR_ILLEGAL_TRAP_EN reports invalid opcodes and read-only write attempts.
module csr_access_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [11:0]       req_addr,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic              req_rs1_zero,
    input  logic [4:0]        req_zimm,
    output logic [11:0]       csr_sel,
    output logic [DATA_W-1:0] csr_wdata,
    output logic              csr_wen,
    input  logic [DATA_W-1:0] csr_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_illegal
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        funct3_q;
    logic [11:0]       addr_q;
    logic [DATA_W-1:0] rs1_q;
    logic              rs1_zero_q;
    logic [4:0]        zimm_q;
    logic [DATA_W-1:0] old_q;

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] wdata;
    logic              invalid;
    logic              read_only;
    logic              write_req;
    logic              do_write;

    assign src       = funct3_q[2] ? {{(DATA_W-5){1'b0}}, zimm_q} : rs1_q;
    assign invalid   = (funct3_q[1:0] == 2'b00);
    assign read_only = (addr_q[11:10] == 2'b11);

    // write_req is the write the opcode asks for, before read-only suppression.
    always_comb begin
        wdata     = '0;
        write_req = 1'b0;
        case (funct3_q[1:0])
            2'b01: begin
                wdata     = src;
                write_req = 1'b1;
            end
            2'b10: begin
                wdata     = old_q | src;
                write_req = funct3_q[2] ? (zimm_q != 5'd0) : !rs1_zero_q;
            end
            2'b11: begin
                wdata     = old_q & ~src;
                write_req = funct3_q[2] ? (zimm_q != 5'd0) : !rs1_zero_q;
            end
            default: begin
                wdata     = '0;
                write_req = 1'b0;
            end
        endcase
    end

    assign do_write = write_req && !read_only;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = READ;
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= 3'd0;
            addr_q     <= 12'd0;
            rs1_q      <= '0;
            rs1_zero_q <= 1'b0;
            zimm_q     <= 5'd0;
            old_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                funct3_q   <= req_funct3;
                addr_q     <= req_addr;
                rs1_q      <= req_rs1;
                rs1_zero_q <= req_rs1_zero;
                zimm_q     <= req_zimm;
            end
            // Invalid opcodes return zero to rd.
            if (state_q == READ) begin
                old_q <= invalid ? '0 : csr_rdata;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign csr_sel   = addr_q;
    assign csr_wdata = wdata;
    assign csr_wen   = (state_q == WRITE) && do_write;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = old_q;

`ifdef CSR_ILLEGAL_TRAP_EN
    assign rsp_illegal = (state_q == RESP) && (invalid || (write_req && read_only));
`else
    assign rsp_illegal = 1'b0;
`endif

endmodule
